// File: rtl/gps_mon_pkg.sv
// rtl/gps_mon_pkg.sv - shared state encoding, fault codes and defaults for the GPS clock-enable monitor
package gps_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACQ   = 2'b01,
        ST_TRACK = 2'b10,
        ST_FAULT = 2'b11
    } mon_state_t;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_EARLY     = 2'b01;
    localparam logic [1:0] FC_LATE      = 2'b10;
    localparam logic [1:0] FC_LOCK_LOST = 2'b11;

    localparam int DEF_DIV       = 10;
    localparam int DEF_EPOCH_LEN = 1023;

endpackage

// File: rtl/gps_period_counter.sv
// rtl/gps_period_counter.sv - saturating strobe-period counter with DIV-1 compare
module gps_period_counter #(
    parameter int DIV   = 10,
    parameter int CNT_W = 8
) (
    input  logic             gps_clk_fast,
    input  logic             gps_rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic             strobe,
    output logic [CNT_W-1:0] count,
    output logic             at_limit,
    output logic             below_limit
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Holds at all-ones rather than wrapping so a missing strobe can never alias to a good period.
    always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
        if (!gps_rst_n) begin
            count <= '0;
        end else if (clr || (run && strobe)) begin
            count <= '0;
        end else if (run && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit    = (count == LIMIT);
    assign below_limit = (count < LIMIT);

endmodule

// File: rtl/gps_clken_monitor.sv
// rtl/gps_clken_monitor.sv - verifies slow_ce cadence against gps_clk_fast and tracks the C/A chip index
module gps_clken_monitor
    import gps_mon_pkg::*;
#(
    parameter int DIV       = DEF_DIV,
    parameter int CNT_W     = 8,
    parameter int LOCK_GOOD = 4,
    parameter int EPOCH_LEN = DEF_EPOCH_LEN
) (
    input  logic             gps_clk_fast,
    input  logic             gps_rst_n,
    input  logic             locked,
    input  logic             slow_ce,
    input  logic             clear,
    output logic             ce_ok,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] period_last,
    output logic [9:0]       chip_idx,
    output logic             epoch
);

    localparam int              GW        = $clog2(LOCK_GOOD + 1);
    localparam logic [GW-1:0]   GOOD_MAX  = GW'(LOCK_GOOD);
    localparam logic [9:0]      CHIP_LAST = 10'(EPOCH_LEN - 1);

    mon_state_t       state, state_n;
    logic [GW-1:0]    good_cnt, good_n;
    logic             fault_n;
    logic [1:0]       code_n;
    logic [CNT_W-1:0] plast_n;
    logic [9:0]       chip_n;
    logic             epoch_n;
    logic             ce_ok_n;

    logic [CNT_W-1:0] count;
    logic             at_limit;
    logic             below_limit;

    gps_period_counter #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_period (
        .gps_clk_fast (gps_clk_fast),
        .gps_rst_n    (gps_rst_n),
        .clr          (state != ST_TRACK),
        .run          (state == ST_TRACK),
        .strobe       (slow_ce),
        .count        (count),
        .at_limit     (at_limit),
        .below_limit  (below_limit)
    );

    always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
        if (!gps_rst_n) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            period_last <= '0;
            chip_idx    <= '0;
            epoch       <= 1'b0;
            ce_ok       <= 1'b0;
        end else begin
            state       <= state_n;
            good_cnt    <= good_n;
            fault       <= fault_n;
            fault_code  <= code_n;
            period_last <= plast_n;
            chip_idx    <= chip_n;
            epoch       <= epoch_n;
            ce_ok       <= ce_ok_n;
        end
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        fault_n = fault;
        code_n  = fault_code;
        plast_n = period_last;
        chip_n  = chip_idx;
        epoch_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (locked) begin
                    state_n = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (!locked) begin
                    state_n = ST_FAULT;
                    fault_n = 1'b1;
                    code_n  = FC_LOCK_LOST;
                end else if (slow_ce) begin
                    state_n = ST_TRACK;
                    good_n  = '0;
                end
            end
            ST_TRACK: begin
                // Lock loss outranks any strobe verdict in the same cycle.
                if (!locked) begin
                    state_n = ST_FAULT;
                    fault_n = 1'b1;
                    code_n  = FC_LOCK_LOST;
                end else if (slow_ce && at_limit) begin
                    plast_n = count + 1'b1;
                    if (good_cnt != GOOD_MAX) begin
                        good_n = good_cnt + 1'b1;
                    end
                    if (chip_idx == CHIP_LAST) begin
                        chip_n  = '0;
                        epoch_n = 1'b1;
                    end else begin
                        chip_n = chip_idx + 1'b1;
                    end
                end else if (slow_ce && below_limit) begin
                    plast_n = count + 1'b1;
                    state_n = ST_FAULT;
                    fault_n = 1'b1;
                    code_n  = FC_EARLY;
                end else if (at_limit) begin
                    state_n = ST_FAULT;
                    fault_n = 1'b1;
                    code_n  = FC_LATE;
                end
            end
            ST_FAULT: begin
                if (clear) begin
                    state_n = ST_IDLE;
                    fault_n = 1'b0;
                    code_n  = FC_NONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (state_n != ST_TRACK) begin
            chip_n  = '0;
            epoch_n = 1'b0;
            good_n  = '0;
        end
        ce_ok_n = (state_n == ST_TRACK) && (good_n == GOOD_MAX);
    end

endmodule

// File: tb/tb_gps_clken_monitor.sv
// tb/tb_gps_clken_monitor.sv - directed vector bench for gps_clken_monitor
module tb_gps_clken_monitor;

    logic       gps_clk_fast;
    logic       gps_rst_n;
    logic       locked;
    logic       slow_ce;
    logic       clear;
    logic       ce_ok;
    logic       fault;
    logic [1:0] fault_code;
    logic [7:0] period_last;
    logic [9:0] chip_idx;
    logic       epoch;

    int n_checks;
    int n_fail;

    gps_clken_monitor dut (
        .gps_clk_fast (gps_clk_fast),
        .gps_rst_n    (gps_rst_n),
        .locked       (locked),
        .slow_ce      (slow_ce),
        .clear        (clear),
        .ce_ok        (ce_ok),
        .fault        (fault),
        .fault_code   (fault_code),
        .period_last  (period_last),
        .chip_idx     (chip_idx),
        .epoch        (epoch)
    );

    initial gps_clk_fast = 1'b0;
    always #5 gps_clk_fast = ~gps_clk_fast;

    typedef struct {
        int         gap;
        logic       lk;
        logic       sc;
        logic       clr;
        logic       e_ok;
        logic       e_fault;
        logic [1:0] e_code;
        logic [7:0] e_plast;
        logic [9:0] e_chip;
        logic       e_epoch;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int gap, input logic lk, input logic sc, input logic clr,
                                input logic ok, input logic f, input logic [1:0] code,
                                input logic [7:0] pl, input logic [9:0] chip, input logic ep);
        vec_t v;
        v.gap = gap; v.lk = lk; v.sc = sc; v.clr = clr;
        v.e_ok = ok; v.e_fault = f; v.e_code = code;
        v.e_plast = pl; v.e_chip = chip; v.e_epoch = ep;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ok, input logic f, input logic [1:0] code,
                           input logic [7:0] pl, input logic [9:0] chip, input logic ep);
        chk({tag, ".ce_ok"},       32'(ce_ok),       32'(ok));
        chk({tag, ".fault"},       32'(fault),       32'(f));
        chk({tag, ".fault_code"},  32'(fault_code),  32'(code));
        chk({tag, ".period_last"}, 32'(period_last), 32'(pl));
        chk({tag, ".chip_idx"},    32'(chip_idx),    32'(chip));
        chk({tag, ".epoch"},       32'(epoch),       32'(ep));
    endtask

    task automatic step(input logic lk, input logic sc, input logic clr);
        @(negedge gps_clk_fast);
        locked  = lk;
        slow_ce = sc;
        clear   = clr;
        @(posedge gps_clk_fast);
        #1;
    endtask

    int epoch_pulses;
    int chip_errs;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        gps_rst_n = 1'b0;
        locked    = 1'b0;
        slow_ce   = 1'b0;
        clear     = 1'b0;

        //   gap lk sc clr  ok f  code plast chip ep
        add(0, 1, 0, 0,   0, 0, 2'd0, 8'd0,  10'd0, 0);
        add(2, 1, 1, 0,   0, 0, 2'd0, 8'd0,  10'd0, 0);
        add(9, 1, 1, 0,   0, 0, 2'd0, 8'd10, 10'd1, 0);
        add(9, 1, 1, 0,   0, 0, 2'd0, 8'd10, 10'd2, 0);
        add(9, 1, 1, 0,   0, 0, 2'd0, 8'd10, 10'd3, 0);
        add(9, 1, 1, 0,   1, 0, 2'd0, 8'd10, 10'd4, 0);
        add(9, 1, 1, 0,   1, 0, 2'd0, 8'd10, 10'd5, 0);
        add(6, 1, 1, 0,   0, 1, 2'd1, 8'd7,  10'd0, 0);
        add(3, 0, 0, 0,   0, 1, 2'd1, 8'd7,  10'd0, 0);
        add(0, 1, 0, 1,   0, 0, 2'd0, 8'd7,  10'd0, 0);
        add(0, 1, 1, 0,   0, 0, 2'd0, 8'd7,  10'd0, 0);
        add(0, 1, 1, 0,   0, 0, 2'd0, 8'd7,  10'd0, 0);
        add(9, 1, 1, 0,   0, 0, 2'd0, 8'd10, 10'd1, 0);
        add(8, 1, 0, 0,   0, 0, 2'd0, 8'd10, 10'd1, 0);
        add(0, 1, 0, 0,   0, 1, 2'd2, 8'd10, 10'd0, 0);
        add(0, 1, 0, 1,   0, 0, 2'd0, 8'd10, 10'd0, 0);
        add(0, 1, 0, 0,   0, 0, 2'd0, 8'd10, 10'd0, 0);
        add(0, 1, 1, 0,   0, 0, 2'd0, 8'd10, 10'd0, 0);
        add(9, 1, 1, 1,   0, 0, 2'd0, 8'd10, 10'd1, 0);
        add(9, 0, 1, 0,   0, 1, 2'd3, 8'd10, 10'd0, 0);
        add(0, 1, 0, 1,   0, 0, 2'd0, 8'd10, 10'd0, 0);
        add(0, 0, 0, 0,   0, 0, 2'd0, 8'd10, 10'd0, 0);
        add(0, 1, 0, 0,   0, 0, 2'd0, 8'd10, 10'd0, 0);
        add(0, 0, 0, 0,   0, 1, 2'd3, 8'd10, 10'd0, 0);
        add(0, 1, 0, 1,   0, 0, 2'd0, 8'd10, 10'd0, 0);
        add(0, 1, 0, 0,   0, 0, 2'd0, 8'd10, 10'd0, 0);
        add(0, 1, 1, 0,   0, 0, 2'd0, 8'd10, 10'd0, 0);
        add(8, 1, 1, 0,   0, 1, 2'd1, 8'd9,  10'd0, 0);
        add(0, 1, 0, 1,   0, 0, 2'd0, 8'd9,  10'd0, 0);

        #12;
        chk_all("reset", 0, 0, 2'd0, 8'd0, 10'd0, 0);
        @(negedge gps_clk_fast);
        gps_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int g = 0; g < vecs[i].gap; g++) step(1'b1, 1'b0, 1'b0);
            step(vecs[i].lk, vecs[i].sc, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_ok, vecs[i].e_fault, vecs[i].e_code,
                    vecs[i].e_plast, vecs[i].e_chip, vecs[i].e_epoch);
        end

        // Epoch wrap: 1023 good strobes from a fresh TRACK entry.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        epoch_pulses = 0;
        chip_errs    = 0;
        for (int i = 1; i <= 1023; i++) begin
            for (int g = 0; g < 9; g++) begin
                step(1'b1, 1'b0, 1'b0);
                if (epoch) epoch_pulses++;
            end
            step(1'b1, 1'b1, 1'b0);
            if (epoch) epoch_pulses++;
            if (chip_idx !== 10'(i % 1023)) chip_errs++;
            if (i == 1022) begin
                chk("wrap.chip_before", 32'(chip_idx), 32'd1022);
                chk("wrap.epoch_before", 32'(epoch), 32'd0);
            end
            if (i == 1023) begin
                chk("wrap.chip_after", 32'(chip_idx), 32'd0);
                chk("wrap.epoch_pulse", 32'(epoch), 32'd1);
                chk("wrap.fault", 32'(fault), 32'd0);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        if (epoch) epoch_pulses++;
        chk("wrap.epoch_next", 32'(epoch), 32'd0);
        chk("wrap.epoch_count", 32'(epoch_pulses), 32'd1);
        chk("wrap.chip_seq_errs", 32'(chip_errs), 32'd0);

        // Async reset mid-TRACK, then history-free restart.
        for (int g = 0; g < 8; g++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 9; g++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_all("pre_rst", 1, 0, 2'd0, 8'd10, 10'd2, 0);
        #2;
        gps_rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 2'd0, 8'd0, 10'd0, 0);
        @(negedge gps_clk_fast);
        gps_rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_all("post_rst_acq", 0, 0, 2'd0, 8'd0, 10'd0, 0);
        for (int g = 0; g < 9; g++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_all("post_rst_good", 0, 0, 2'd0, 8'd10, 10'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
